// File: rtl/lim_counter_chain_pkg.sv
// Shared constants and helpers for the limited-modulus counter chain.
package lim_cnt_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Stopwatch mm:ss.cc: digit moduli from LSB are 10,10,10,6,10,6
  localparam logic [23:0] SW_LIMITS = 24'h6A6AAA;

  // Extract the w-bit modulus of digit k from a packed limits vector
  function automatic logic [7:0] lim_of(input logic [63:0] limits, input int k,
                                        input int w = 4);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return 8'((limits >> (k * w)) & mask);
  endfunction

endpackage

// File: rtl/lim_counter_chain_if.sv
// Control/data bundle between the tick source, the counter chain and the display.
interface lim_counter_chain_if #(
  parameter int N = 6,
  parameter int W = 4
);
  logic           en;
  logic           dir;
  logic           clr;
  logic           load;
  logic [N*W-1:0] load_val;
  logic [N*W-1:0] digits;
  logic           tc;
  logic           load_err;

  modport master (
    output en, dir, clr, load, load_val,
    input  digits, tc, load_err
  );

  modport slave (
    input  en, dir, clr, load, load_val,
    output digits, tc, load_err
  );
endinterface

// File: rtl/lim_counter_chain_digit.sv
// One registered digit with its own modulus; steps up or down when told to.
module lim_digit
  import lim_cnt_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic         dir,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic [W-1:0] limit,
  output logic [W-1:0] q,
  output logic         at_max,
  output logic         at_zero
);

  logic [W-1:0] q_d, q_q;
  logic [W-1:0] lim_m1;

  assign lim_m1  = limit - W'(1);
  assign at_max  = (q_q == lim_m1);
  assign at_zero = (q_q == '0);
  assign q       = q_q;

  // Next digit value: clear, then load (out-of-range forced to 0), then step
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = (ld_val < limit) ? ld_val : '0;
    end else if (step) begin
      if (dir == DIR_UP) begin
        q_d = at_max ? '0 : q_q + W'(1);
      end else begin
        q_d = at_zero ? lim_m1 : q_q - W'(1);
      end
    end
  end

  // Digit register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/lim_counter_chain.sv
// Cascade of limited-modulus digits with carry/borrow ripple, terminal-count
// pulse (optionally one-shot at a saturated end) and load-range error pulse.
module lim_counter_chain
  import lim_cnt_pkg::*;
#(
  parameter int             N        = 6,
  parameter int             W        = 4,
  parameter logic [N*W-1:0] LIMITS   = (N*W)'(SW_LIMITS),
  parameter bit             HOLD_END = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  lim_counter_chain_if.slave  bus
);

  logic [W-1:0]   q [N];
  logic [N-1:0]   at_max;
  logic [N-1:0]   at_zero;
  logic [N-1:0]   step;
  logic [N-1:0]   ld_bad;
  logic [N:0]     up_chain;
  logic [N:0]     dn_chain;
  logic           at_end;
  logic           count_go;
  logic [N*W-1:0] digits_flat;

  logic tc_d, tc_q;
  logic armed_d, armed_q;
  logic load_err_d, load_err_q;

  // Carry/borrow AND-chains: digit k moves iff all lower digits sit at their end
  always_comb begin
    up_chain[0] = 1'b1;
    dn_chain[0] = 1'b1;
    for (int k = 0; k < N; k++) begin
      up_chain[k+1] = up_chain[k] & at_max[k];
      dn_chain[k+1] = dn_chain[k] & at_zero[k];
    end
  end

  assign at_end   = bus.en & ((bus.dir == DIR_UP) ? up_chain[N] : dn_chain[N]);
  // In hold mode the end step is suppressed so the chain saturates
  assign count_go = bus.en & ~bus.clr & ~bus.load & ~(HOLD_END & at_end);

  for (genvar k = 0; k < N; k++) begin : g_dig
    localparam logic [W-1:0] LIM_K = W'(lim_of(64'(LIMITS), k, W));

    assign step[k]   = count_go & ((bus.dir == DIR_UP) ? up_chain[k] : dn_chain[k]);
    assign ld_bad[k] = (bus.load_val[k*W +: W] >= LIM_K);

    lim_digit #(.W(W)) u_digit (
      .clk     (clk),
      .rst_n   (rst_n),
      .step    (step[k]),
      .dir     (bus.dir),
      .clr     (bus.clr),
      .load    (bus.load),
      .ld_val  (bus.load_val[k*W +: W]),
      .limit   (LIM_K),
      .q       (q[k]),
      .at_max  (at_max[k]),
      .at_zero (at_zero[k])
    );
  end

  // Pack the digit registers into the output bus
  always_comb begin
    digits_flat = '0;
    for (int k = 0; k < N; k++) begin
      digits_flat[k*W +: W] = q[k];
    end
  end

  assign bus.digits   = digits_flat;
  assign bus.tc       = tc_q;
  assign bus.load_err = load_err_q;

  // Terminal count and its one-shot arming; any real movement of the chain re-arms
  always_comb begin
    tc_d       = 1'b0;
    armed_d    = armed_q;
    load_err_d = 1'b0;
    if (bus.clr) begin
      armed_d = 1'b1;
    end else if (bus.load) begin
      armed_d    = 1'b1;
      load_err_d = |ld_bad;
    end else if (bus.en) begin
      if (at_end) begin
        if (HOLD_END) begin
          tc_d    = armed_q;
          armed_d = 1'b0;
        end else begin
          tc_d = 1'b1;
        end
      end else begin
        armed_d = 1'b1;
      end
    end
  end

  // Flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_q       <= 1'b0;
      armed_q    <= 1'b1;
      load_err_q <= 1'b0;
    end else begin
      tc_q       <= tc_d;
      armed_q    <= armed_d;
      load_err_q <= load_err_d;
    end
  end

endmodule

// File: tb/tb_lim_counter_chain.sv
// Bench for lim_counter_chain: wrap and hold variants driven in lockstep,
// checked against a mixed-radix integer model plus literal expectations.
module tb_lim_counter_chain;

  localparam int M = 360000;  // product of all digit moduli

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_s = 1'b0, dir_s = 1'b0, clr_s = 1'b0, load_s = 1'b0;
  logic [23:0] lv_s = '0;

  int lims [6] = '{10, 10, 10, 6, 10, 6};
  int errors = 0;
  int checks = 0;

  // model state
  int mv0 = 0, mv1 = 0;
  bit mtc0 = 0, mtc1 = 0, merr = 0, mfired = 0;

  always #5 clk = ~clk;

  lim_counter_chain_if #(.N(6), .W(4)) if0 ();
  lim_counter_chain_if #(.N(6), .W(4)) if1 ();

  assign if0.en = en_s;   assign if1.en = en_s;
  assign if0.dir = dir_s; assign if1.dir = dir_s;
  assign if0.clr = clr_s; assign if1.clr = clr_s;
  assign if0.load = load_s; assign if1.load = load_s;
  assign if0.load_val = lv_s; assign if1.load_val = lv_s;

  lim_counter_chain #(.N(6), .W(4), .LIMITS(24'h6A6AAA), .HOLD_END(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  lim_counter_chain #(.N(6), .W(4), .LIMITS(24'h6A6AAA), .HOLD_END(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  function automatic logic [23:0] to_dig(input int v);
    logic [23:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < 6; k++) begin
      r[k*4 +: 4] = 4'(t % lims[k]);
      t = t / lims[k];
    end
    return r;
  endfunction

  function automatic void from_load(input logic [23:0] lv, output int v, output bit bad);
    int mul, d;
    v = 0; mul = 1; bad = 0;
    for (int k = 0; k < 6; k++) begin
      d = int'(lv[k*4 +: 4]);
      if (d >= lims[k]) begin
        bad = 1;
        d = 0;
      end
      v = v + d * mul;
      mul = mul * lims[k];
    end
  endfunction

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the count is one integer in 0..M-1
  always @(posedge clk or negedge rst_n) begin : model
    int nv;
    bit b, end0, end1;
    if (!rst_n) begin
      mv0 <= 0; mv1 <= 0; mtc0 <= 0; mtc1 <= 0; merr <= 0; mfired <= 0;
    end else if (clr_s) begin
      mv0 <= 0; mv1 <= 0; mtc0 <= 0; mtc1 <= 0; merr <= 0; mfired <= 0;
    end else if (load_s) begin
      from_load(lv_s, nv, b);
      mv0 <= nv; mv1 <= nv; merr <= b; mtc0 <= 0; mtc1 <= 0; mfired <= 0;
    end else begin
      merr <= 0;
      if (en_s) begin
        end0 = dir_s ? (mv0 == 0) : (mv0 == M - 1);
        end1 = dir_s ? (mv1 == 0) : (mv1 == M - 1);
        mv0  <= dir_s ? (mv0 + M - 1) % M : (mv0 + 1) % M;
        mtc0 <= end0;
        if (end1) begin
          mtc1   <= !mfired;
          mfired <= 1;
        end else begin
          mv1    <= dir_s ? mv1 - 1 : mv1 + 1;
          mtc1   <= 0;
          mfired <= 0;
        end
      end else begin
        mtc0 <= 0;
        mtc1 <= 0;
      end
    end
  end

  // Compare process: every falling edge, both DUTs against the model
  always @(negedge clk) begin
    chk("digits_wrap", if0.digits, to_dig(mv0));
    chk("tc_wrap", {23'd0, if0.tc}, {23'd0, mtc0});
    chk("lderr_wrap", {23'd0, if0.load_err}, {23'd0, merr});
    chk("digits_hold", if1.digits, to_dig(mv1));
    chk("tc_hold", {23'd0, if1.tc}, {23'd0, mtc1});
    chk("lderr_hold", {23'd0, if1.load_err}, {23'd0, merr});
  end

  task automatic cyc(input bit e, input bit d, input bit c, input bit l, input logic [23:0] v);
    en_s = e; dir_s = d; clr_s = c; load_s = l; lv_s = v;
    @(negedge clk);
  endtask

  initial begin
    int r;
    logic [23:0] v;
    bit d;
    @(negedge clk);
    @(negedge clk);
    chk("reset_digits", if0.digits, 24'h000000);
    chk("reset_tc", {23'd0, if0.tc}, 24'h0);
    rst_n = 1'b1;

    // 137 up ticks, then asynchronous reset mid-cycle
    repeat (137) cyc(1, 0, 0, 0, 24'h0);
    chk("count137", if0.digits, 24'h000137);
    chk("count137_hold", if1.digits, 24'h000137);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", if0.digits, 24'h000000);
    en_s = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // up wrap versus up saturate
    cyc(0, 0, 0, 1, 24'h595999);
    cyc(1, 0, 0, 0, 24'h0);
    chk("wrap_up", if0.digits, 24'h000000);
    chk("wrap_up_tc", {23'd0, if0.tc}, 24'h1);
    chk("hold_up", if1.digits, 24'h595999);
    chk("hold_up_tc", {23'd0, if1.tc}, 24'h1);
    cyc(0, 0, 0, 0, 24'h0);
    chk("tc_one_cycle", {23'd0, if0.tc}, 24'h0);
    repeat (5) cyc(1, 0, 0, 0, 24'h0);
    chk("hold_stays", if1.digits, 24'h595999);
    chk("hold_no_tc", {23'd0, if1.tc}, 24'h0);
    cyc(1, 1, 0, 0, 24'h0);
    chk("hold_dir_down", if1.digits, 24'h595998);

    // down wrap and down borrow ripple
    cyc(0, 0, 1, 0, 24'h0);
    cyc(1, 1, 0, 0, 24'h0);
    chk("wrap_down", if0.digits, 24'h595999);
    chk("wrap_down_tc", {23'd0, if0.tc}, 24'h1);
    cyc(0, 0, 0, 1, 24'h001000);
    cyc(1, 1, 0, 0, 24'h0);
    chk("borrow", if0.digits, 24'h000999);

    // out-of-range load
    cyc(0, 0, 0, 1, 24'h0C0A07);
    chk("bad_load", if0.digits, 24'h000007);
    chk("bad_load_err", {23'd0, if0.load_err}, 24'h1);
    cyc(0, 0, 0, 0, 24'h0);
    chk("load_err_pulse", {23'd0, if0.load_err}, 24'h0);

    // priority
    cyc(0, 0, 0, 1, 24'h595999);
    cyc(1, 0, 1, 1, 24'h123456);
    chk("prio_clr", if0.digits, 24'h000000);
    chk("prio_clr_tc", {23'd0, if0.tc}, 24'h0);
    cyc(1, 0, 0, 1, 24'h000009);
    chk("prio_load", if0.digits, 24'h000009);

    // randomized traffic
    d = 1'b0;
    repeat (4000) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 7) == 0) d = ~d;
      case ($urandom_range(0, 3))
        0: v = 24'h595999;
        1: v = 24'h000000;
        2: v = 24'h595995;
        default: v = 24'($urandom());
      endcase
      cyc($urandom_range(0, 9) < 8, d, r < 2, (r >= 2) && (r < 8), v);
    end

    cyc(0, 0, 0, 0, 24'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
